mem_lsu: RTL and testbench

Load/store initiator that drives the single-port-per-direction data memory interface: raddr/ren/rdata on the read side and waddr/wdata/wmask/wen on the write side. The memory uses word addresses, returns registered read data one cycle after ren, and commits masked writes on the clock edge where wen is high. The block sits between the core's execute stage and that memory. It accepts one byte/half/word request at a time and converts the byte address into word-addressed beats. Accesses that cross a word boundary are split into two beats; load data is merged and sign- or zero-extended.

---
 rtl/mem_lsu.sv | 218 +++++++++++++++++++++
 tb/tb_mem_lsu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store initiator: converts byte/half/word requests into word-addressed
// memory beats, splitting word-crossing accesses and merging/extending loads.
module mem_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  output logic                  mem_wen
);
  localparam int WAW = ADDR_WIDTH - 2;
  localparam logic [WAW-1:0] WORD_ONE = {{(WAW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, WAIT} state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] x, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'b00:   extend = uns ? {24'h000000, x[7:0]} : {{24{x[7]}}, x[7:0]};
      2'b01:   extend = uns ? {16'h0000, x[15:0]} : {{16{x[15]}}, x[15:0]};
      default: extend = x;
    endcase
  endfunction

  state_t                  state_r;
  logic                    req_ready_r;
  logic                    resp_valid_r;
  logic [DATA_WIDTH-1:0]   resp_rdata_r;
  logic                    we_r;
  logic                    uns_r;
  logic                    split_r;
  logic [1:0]              size_r;
  logic [1:0]              off_r;
  logic [WAW-1:0]          word_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [DATA_WIDTH-1:0]   buf0_r;
  logic [ADDR_WIDTH-1:0]   mem_raddr_r;
  logic [ADDR_WIDTH-1:0]   mem_waddr_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;
  logic [3:0]              mem_wmask_r;
  logic                    mem_ren_r;
  logic                    mem_wen_r;

  logic [2:0]              req_n_s;
  logic                    req_split_s;
  logic [3:0]              req_mask0_s;
  logic [DATA_WIDTH-1:0]   req_wdata0_s;
  logic [3:0]              lat_mask1_s;
  logic [DATA_WIDTH-1:0]   lat_wdata1_s;
  logic [DATA_WIDTH-1:0]   merge_lo_s;
  logic [DATA_WIDTH-1:0]   merge_hi_s;
  logic [DATA_WIDTH-1:0]   merged_s;
  logic [DATA_WIDTH-1:0]   load_data_s;

  // Beat-0 lanes and data straight from the incoming request
  always_comb begin
    req_n_s      = size_bytes(req_size);
    req_split_s  = (({1'b0, req_addr[1:0]} + req_n_s) > 3'd4);
    req_mask0_s  = lane_mask(req_n_s) << req_addr[1:0];
    req_wdata0_s = req_wdata << {req_addr[1:0], 3'b000};
  end

  // Beat-1 lanes/data and the merged, extended load result from latched state
  always_comb begin
    lat_mask1_s  = lane_mask(size_bytes(size_r)) >> (3'd4 - {1'b0, off_r});
    lat_wdata1_s = wdata_r >> (6'd32 - {1'b0, off_r, 3'b000});
    if (split_r) begin
      merge_lo_s = buf0_r;
      merge_hi_s = mem_rdata;
    end else begin
      merge_lo_s = mem_rdata;
      merge_hi_s = 32'h0000_0000;
    end
    merged_s    = 32'({merge_hi_s, merge_lo_s} >> {off_r, 3'b000});
    load_data_s = extend(merged_s, size_r, uns_r);
  end

  // Request FSM; every memory-side output is registered for the following beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      we_r         <= 1'b0;
      uns_r        <= 1'b0;
      split_r      <= 1'b0;
      size_r       <= 2'b00;
      off_r        <= 2'b00;
      word_r       <= '0;
      wdata_r      <= 32'h0000_0000;
      buf0_r       <= 32'h0000_0000;
      mem_raddr_r  <= '0;
      mem_waddr_r  <= '0;
      mem_wdata_r  <= 32'h0000_0000;
      mem_wmask_r  <= 4'b0000;
      mem_ren_r    <= 1'b0;
      mem_wen_r    <= 1'b0;
    end else begin
      resp_valid_r <= 1'b0;
      mem_raddr_r  <= '0;
      mem_waddr_r  <= '0;
      mem_wdata_r  <= 32'h0000_0000;
      mem_wmask_r  <= 4'b0000;
      mem_ren_r    <= 1'b0;
      mem_wen_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            state_r     <= BEAT0;
            req_ready_r <= 1'b0;
            we_r        <= req_we;
            uns_r       <= req_unsigned;
            size_r      <= req_size;
            off_r       <= req_addr[1:0];
            word_r      <= req_addr[ADDR_WIDTH-1:2];
            wdata_r     <= req_wdata;
            split_r     <= req_split_s;
            if (req_we) begin
              mem_wen_r   <= 1'b1;
              mem_waddr_r <= {2'b00, req_addr[ADDR_WIDTH-1:2]};
              mem_wmask_r <= req_mask0_s;
              mem_wdata_r <= req_wdata0_s;
            end else begin
              mem_ren_r   <= 1'b1;
              mem_raddr_r <= {2'b00, req_addr[ADDR_WIDTH-1:2]};
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        BEAT0: begin
          if (split_r) begin
            state_r <= BEAT1;
            if (we_r) begin
              mem_wen_r   <= 1'b1;
              mem_waddr_r <= {2'b00, word_r + WORD_ONE};
              mem_wmask_r <= lat_mask1_s;
              mem_wdata_r <= lat_wdata1_s;
            end else begin
              mem_ren_r   <= 1'b1;
              mem_raddr_r <= {2'b00, word_r + WORD_ONE};
            end
          end else if (we_r) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b1;
          end else begin
            state_r <= WAIT;
          end
        end
        BEAT1: begin
          if (we_r) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b1;
          end else begin
            buf0_r  <= mem_rdata;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          resp_rdata_r <= load_data_s;
          resp_valid_r <= 1'b1;
          req_ready_r  <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Enables are qualified by reset so a beat in flight when reset arrives never commits
  assign mem_ren    = mem_ren_r & rst_n;
  assign mem_wen    = mem_wen_r & rst_n;
  assign mem_wmask  = mem_wmask_r & {4{rst_n}};
  assign mem_raddr  = mem_raddr_r;
  assign mem_waddr  = mem_waddr_r;
  assign mem_wdata  = mem_wdata_r;
  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: stimulus pushes expected beats/responses,
// a negedge monitor compares every cycle against them.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] mem_raddr;
  logic        mem_ren;
  logic [31:0] mem_rdata;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wen;

  typedef struct packed {
    int          at;
    logic        is_load;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    int          at;
    logic [31:0] data;
  } resp_t;

  beat_t       beat_q[$];
  resp_t       resp_q[$];
  int          cyc    = 0;
  int          checks = 0;
  int          fails  = 0;
  int          last_t = 0;
  int          t_st;
  int          t_rst;
  logic [31:0] mem [0:7];

  mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wen(mem_wen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word-addressed memory model: registered read, masked write on wen
  always @(posedge clk) begin
    if (cyc == 0) begin
      mem[0]    <= 32'h4433_2211;
      mem[1]    <= 32'h8877_6655;
      mem[2]    <= 32'h0000_0000;
      mem[3]    <= 32'h9999_9999;
      mem[4]    <= 32'h0000_0000;
      mem[5]    <= 32'h0000_0000;
      mem[6]    <= 32'h0000_0000;
      mem[7]    <= 32'hA1A2_A3A4;
      mem_rdata <= 32'h0000_0000;
    end else begin
      if (mem_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wmask[b]) mem[mem_waddr[2:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
      if (mem_ren) mem_rdata <= mem[mem_raddr[2:0]];
    end
  end

  function automatic void check(input string name, input logic [127:0] got,
                                input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endfunction

  // Monitor: every cycle the bus and response are either the expected beat or quiet
  always @(negedge clk) begin
    beat_t mb;
    resp_t mr;
    if (!rst_n) begin
      check("bus_quiet_in_reset", 128'({mem_ren, mem_wen}), 128'h0);
    end else if (beat_q.size() > 0 && beat_q[0].at == cyc) begin
      mb = beat_q.pop_front();
      if (mb.is_load)
        check("load_beat", 128'({mem_ren, mem_wen, mem_raddr, mem_wmask}),
              128'({1'b1, 1'b0, mb.addr, 4'b0000}));
      else
        check("store_beat", 128'({mem_ren, mem_wen, mem_waddr, mem_wdata, mem_wmask}),
              128'({1'b0, 1'b1, mb.addr, mb.wdata, mb.mask}));
    end else begin
      check("bus_idle", 128'({mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask}),
            128'h0);
    end
    if (resp_q.size() > 0 && resp_q[0].at == cyc) begin
      mr = resp_q.pop_front();
      check("response", 128'({resp_valid, resp_rdata}), 128'({1'b1, mr.data}));
    end else begin
      check("no_response", 128'(resp_valid), 128'h0);
    end
  end

  task automatic push_ld(input int at, input logic [31:0] addr);
    beat_t b;
    b.at = at; b.is_load = 1'b1; b.addr = addr; b.mask = 4'b0000; b.wdata = 32'h0;
    beat_q.push_back(b);
  endtask

  task automatic push_st(input int at, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] wdata);
    beat_t b;
    b.at = at; b.is_load = 1'b0; b.addr = addr; b.mask = mask; b.wdata = wdata;
    beat_q.push_back(b);
  endtask

  task automatic push_resp(input int at, input logic [31:0] data);
    resp_t r;
    r.at = at; r.data = data;
    resp_q.push_back(r);
  endtask

  // Called just after a rising edge; returns the accept cycle or -1 on timeout
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output int t);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout cycle %0d: got no req_ready expected accept", cyc);
    end else begin
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [31:0] ra0, input logic split, input logic [31:0] ra1,
                         input logic [31:0] expv);
    int t;
    issue(1'b0, size, uns, addr, 32'h0, t);
    if (t >= 0) begin
      push_ld(t + 1, ra0);
      if (split) push_ld(t + 2, ra1);
      push_resp(t + (split ? 4 : 3), expv);
    end
    last_t = t;
  endtask

  task automatic do_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] wa0, input logic [3:0] m0, input logic [31:0] wd0,
                          input logic split, input logic [31:0] wa1, input logic [3:0] m1,
                          input logic [31:0] wd1, input logic [31:0] rexp);
    int t;
    issue(1'b1, size, 1'b0, addr, wd, t);
    if (t >= 0) begin
      push_st(t + 1, wa0, m0, wd0);
      if (split) push_st(t + 2, wa1, m1, wd1);
      push_resp(t + (split ? 3 : 2), rexp);
    end
    last_t = t;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 128'(req_ready), 128'h1);
    check("rdata_after_reset", 128'(resp_rdata), 128'h0);
    @(posedge clk);
    #1;

    do_load(2'b10, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 32'h4433_2211);
    do_load(2'b00, 1'b0, 32'h0000_0007, 32'h1, 1'b0, 32'h0, 32'hFFFF_FF88);
    do_load(2'b00, 1'b1, 32'h0000_0007, 32'h1, 1'b0, 32'h0, 32'h0000_0088);
    do_load(2'b00, 1'b0, 32'h0000_0003, 32'h0, 1'b0, 32'h0, 32'h0000_0044);
    do_load(2'b01, 1'b1, 32'h0000_0006, 32'h1, 1'b0, 32'h0, 32'h0000_8877);
    do_load(2'b10, 1'b0, 32'h0000_0001, 32'h0, 1'b1, 32'h1, 32'h5544_3322);
    do_load(2'b01, 1'b0, 32'h0000_0003, 32'h0, 1'b1, 32'h1, 32'h0000_5544);
    do_load(2'b10, 1'b0, 32'hFFFF_FFFE, 32'h3FFF_FFFF, 1'b1, 32'h0, 32'h2211_A1A2);

    do_store(2'b01, 32'h0000_0003, 32'h0000_BEEF, 32'h0, 4'b1000, 32'hEF00_0000,
             1'b1, 32'h1, 4'b0001, 32'h0000_00BE, 32'h2211_A1A2);
    do_load(2'b10, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 32'hEF33_2211);
    do_load(2'b10, 1'b0, 32'h0000_0004, 32'h1, 1'b0, 32'h0, 32'h8877_66BE);

    do_store(2'b10, 32'h0000_0008, 32'hCAFE_F00D, 32'h2, 4'b1111, 32'hCAFE_F00D,
             1'b0, 32'h0, 4'b0000, 32'h0, 32'h8877_66BE);
    t_st = last_t;
    do_load(2'b10, 1'b0, 32'h0000_0008, 32'h2, 1'b0, 32'h0, 32'hCAFE_F00D);
    check("back_to_back_accept", 128'(last_t), 128'(t_st + 2));

    do_store(2'b00, 32'h0000_0009, 32'h0000_00AB, 32'h2, 4'b0010, 32'h0000_AB00,
             1'b0, 32'h0, 4'b0000, 32'h0, 32'hCAFE_F00D);
    do_load(2'b11, 1'b0, 32'h0000_0008, 32'h2, 1'b0, 32'h0, 32'hCAFE_AB0D);
    do_load(2'b01, 1'b0, 32'h0000_000A, 32'h2, 1'b0, 32'h0, 32'hFFFF_CAFE);
    do_load(2'b00, 1'b1, 32'h0000_0009, 32'h2, 1'b0, 32'h0, 32'h0000_00AB);

    // Split store interrupted by reset while its second beat is on the bus
    issue(1'b1, 2'b01, 1'b0, 32'h0000_000B, 32'h0000_1357, t_rst);
    if (t_rst >= 0) push_st(t_rst + 1, 32'h2, 4'b1000, 32'h5700_0000);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", 128'(req_ready), 128'h1);
    check("rdata_after_midreset", 128'(resp_rdata), 128'h0);
    @(posedge clk);
    #1;
    do_load(2'b10, 1'b0, 32'h0000_0008, 32'h2, 1'b0, 32'h0, 32'h57FE_AB0D);
    do_load(2'b10, 1'b0, 32'h0000_000C, 32'h3, 1'b0, 32'h0, 32'h9999_9999);

    repeat (8) @(posedge clk);
    check("queues_drained", 128'(beat_q.size() + resp_q.size()), 128'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle %0d: got no end of test expected completion", cyc);
    $fatal(1);
  end

endmodule
